// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, fetch FSM encodings,
// and small address helpers used when forming redirect targets.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES      = 32'd4;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'b00,
        FETCH_RUN  = 2'b01,
        FETCH_HALT = 2'b10
    } fetch_state_t;

    // J-type target: upper nibble comes from the PC+4 of the jump itself.
    function automatic logic [31:0] jump_address(input logic [31:0] link_pc,
                                                 input logic [25:0] index);
        return {link_pc[31:28], index, 2'b00};
    endfunction

    function automatic logic word_aligned(input logic [31:0] address);
        return (address[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load captures a new instruction, squash inserts a
// bubble while keeping the previous payload, neither means hold.
module if_id_register
    import instruction_fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        squash,
    input  logic [31:0] next_instruction,
    input  logic [31:0] next_pc_plus_4,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus_4,
    output logic        valid
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            instruction <= NOP_INSTRUCTION;
            pc_plus_4   <= 32'h0;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= next_instruction;
            pc_plus_4   <= next_pc_plus_4;
            valid       <= 1'b1;
        end else if (squash) begin
            valid       <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, requests words from instruction memory and loads
// IF/ID; handles stall and decode-resolved jump/branch redirects.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         jump,
    input  logic [25:0]  jump_target,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic [31:0]  imem_rdata,
    input  logic         imem_ready,
    output logic [31:0]  instruction,
    output logic [31:0]  pc_plus_4,
    output logic         valid,
    output logic         fetch_error,
    output fetch_state_t fetch_state
);

    // Memory handshake: a word transfers on a cycle with imem_req=1 and
    // imem_ready=1, in which imem_rdata belongs to imem_addr; while
    // imem_ready=0 the request and address are held unchanged, and
    // imem_rdata is never used when either signal is low.

    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        advance;
    logic        redirect;
    logic        misaligned_branch;
    logic        load;
    logic        squash;

    always_comb begin
        pc_next_seq       = pc + WORD_BYTES;
        advance           = (fetch_state == FETCH_RUN) && !stall;
        redirect          = jump || branch_taken;
        misaligned_branch = !jump && branch_taken && !word_aligned(branch_target);
        // A redirect squashes whatever word came back in the same cycle.
        load              = advance && !redirect && imem_ready;
        squash            = (fetch_state != FETCH_RUN) || (advance && !load);
        imem_req          = advance;
        imem_addr         = pc;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_state <= FETCH_BOOT;
            pc          <= {RESET_PC[31:2], 2'b00};
            fetch_error <= 1'b0;
        end else begin
            case (fetch_state)
                FETCH_BOOT: begin
                    fetch_state <= FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (!stall) begin
                        if (jump) begin
                            pc <= jump_address(pc_plus_4, jump_target);
                        end else if (branch_taken) begin
                            if (misaligned_branch) begin
                                fetch_state <= FETCH_HALT;
                                fetch_error <= 1'b1;
                            end else begin
                                pc <= branch_target;
                            end
                        end else if (imem_ready) begin
                            pc <= pc_next_seq;
                        end
                    end
                end
                FETCH_HALT: begin
                    fetch_error <= 1'b1;
                end
                default: begin
                    fetch_state <= FETCH_HALT;
                    fetch_error <= 1'b1;
                end
            endcase
        end
    end

    if_id_register u_if_id (
        .clock            (clock),
        .reset            (reset),
        .load             (load),
        .squash           (squash),
        .next_instruction (imem_rdata),
        .next_pc_plus_4   (pc_next_seq),
        .instruction      (instruction),
        .pc_plus_4        (pc_plus_4),
        .valid            (valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table with IF/ID scoreboard, reset/HALT
// sequences, and a random memory-wait run.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic         clock;
    logic         reset;
    logic         stall;
    logic         jump;
    logic [25:0]  jump_target;
    logic         branch_taken;
    logic [31:0]  branch_target;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic [31:0]  imem_rdata;
    logic         imem_ready;
    logic [31:0]  instruction;
    logic [31:0]  pc_plus_4;
    logic         valid;
    logic         fetch_error;
    fetch_state_t fetch_state;

    logic [31:0]  mem_key;
    int           checks;
    int           errors;
    logic [63:0]  exp_q[$];

    typedef struct {
        logic         stall;
        logic         jump;
        logic [25:0]  jt;
        logic         bt;
        logic [31:0]  btgt;
        logic         rdy;
        logic         req;
        logic [31:0]  addr;
        logic         vld;
        logic [31:0]  ins;
        logic [31:0]  p4;
        logic         ferr;
        fetch_state_t st;
    } vec_t;

    vec_t vecs[21];

    instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .instruction   (instruction),
        .pc_plus_4     (pc_plus_4),
        .valid         (valid),
        .fetch_error   (fetch_error),
        .fetch_state   (fetch_state)
    );

    // Clock and memory model: word = address ^ mem_key.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    assign imem_rdata = imem_addr ^ mem_key;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic j, input logic [25:0] jt,
                                input logic b, input logic [31:0] bt, input logic r,
                                input logic q, input logic [31:0] a, input logic v,
                                input logic [31:0] i, input logic [31:0] p,
                                input logic fe, input fetch_state_t st);
        vec_t x;
        x.stall = s; x.jump = j; x.jt = jt; x.bt = b; x.btgt = bt; x.rdy = r;
        x.req = q; x.addr = a; x.vld = v; x.ins = i; x.p4 = p; x.ferr = fe; x.st = st;
        return x;
    endfunction

    task automatic drive(input logic s, input logic j, input logic [25:0] jt,
                         input logic b, input logic [31:0] bt, input logic r);
        stall = s; jump = j; jump_target = jt;
        branch_taken = b; branch_target = bt; imem_ready = r;
    endtask

    task automatic edge_step();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_compare(input string name);
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected word %h with empty queue", name, instruction);
        end else begin
            e = exp_q.pop_front();
            check({name, "_instr"}, instruction, e[63:32]);
            check({name, "_pc4"}, pc_plus_4, e[31:0]);
        end
    endtask

    initial begin
        logic [31:0] mpc;
        logic        rdy;
        checks  = 0;
        errors  = 0;
        mem_key = 32'h0;
        reset   = 1'b0;
        drive(1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);

        //           s  j  jt        b  btgt           r  req addr          v  ins            p4             fe st
        vecs[0]  = mk(0, 0, 26'h0,   0, 32'h0,         1, 0, 32'h100,       0, 32'h0,         32'h0,         0, FETCH_RUN);
        vecs[1]  = mk(0, 0, 26'h0,   0, 32'h0,         1, 1, 32'h100,       1, 32'h100,       32'h104,       0, FETCH_RUN);
        vecs[2]  = mk(0, 0, 26'h0,   0, 32'h0,         1, 1, 32'h104,       1, 32'h104,       32'h108,       0, FETCH_RUN);
        vecs[3]  = mk(0, 0, 26'h0,   0, 32'h0,         1, 1, 32'h108,       1, 32'h108,       32'h10C,       0, FETCH_RUN);
        vecs[4]  = mk(0, 1, 26'h2,   0, 32'h0,         1, 1, 32'h10C,       0, 32'h108,       32'h10C,       0, FETCH_RUN);
        vecs[5]  = mk(0, 0, 26'h0,   0, 32'h0,         0, 1, 32'h8,         0, 32'h108,       32'h10C,       0, FETCH_RUN);
        vecs[6]  = mk(0, 0, 26'h0,   0, 32'h0,         0, 1, 32'h8,         0, 32'h108,       32'h10C,       0, FETCH_RUN);
        vecs[7]  = mk(0, 0, 26'h0,   0, 32'h0,         0, 1, 32'h8,         0, 32'h108,       32'h10C,       0, FETCH_RUN);
        vecs[8]  = mk(0, 0, 26'h0,   0, 32'h0,         1, 1, 32'h8,         1, 32'h8,         32'hC,         0, FETCH_RUN);
        vecs[9]  = mk(1, 1, 26'h3FF, 1, 32'h300,       1, 0, 32'hC,         1, 32'h8,         32'hC,         0, FETCH_RUN);
        vecs[10] = mk(1, 0, 26'h0,   1, 32'h202,       1, 0, 32'hC,         1, 32'h8,         32'hC,         0, FETCH_RUN);
        vecs[11] = mk(0, 0, 26'h0,   0, 32'h0,         1, 1, 32'hC,         1, 32'hC,         32'h10,        0, FETCH_RUN);
        vecs[12] = mk(0, 0, 26'h0,   1, 32'h4000_000C, 1, 1, 32'h10,        0, 32'hC,         32'h10,        0, FETCH_RUN);
        vecs[13] = mk(0, 0, 26'h0,   0, 32'h0,         1, 1, 32'h4000_000C, 1, 32'h4000_000C, 32'h4000_0010, 0, FETCH_RUN);
        vecs[14] = mk(0, 1, 26'h40,  1, 32'h300,       1, 1, 32'h4000_0010, 0, 32'h4000_000C, 32'h4000_0010, 0, FETCH_RUN);
        vecs[15] = mk(0, 0, 26'h0,   0, 32'h0,         1, 1, 32'h4000_0100, 1, 32'h4000_0100, 32'h4000_0104, 0, FETCH_RUN);
        vecs[16] = mk(0, 0, 26'h0,   1, 32'hFFFF_FFFC, 1, 1, 32'h4000_0104, 0, 32'h4000_0100, 32'h4000_0104, 0, FETCH_RUN);
        vecs[17] = mk(0, 0, 26'h0,   0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0,         0, FETCH_RUN);
        vecs[18] = mk(0, 0, 26'h0,   0, 32'h0,         1, 1, 32'h0,         1, 32'h0,         32'h4,         0, FETCH_RUN);
        vecs[19] = mk(0, 0, 26'h0,   1, 32'h202,       1, 1, 32'h4,         0, 32'h0,         32'h4,         1, FETCH_HALT);
        vecs[20] = mk(0, 1, 26'h10,  1, 32'h200,       1, 0, 32'h4,         0, 32'h0,         32'h4,         1, FETCH_HALT);

        // Reset block.
        repeat (2) edge_step();
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_instr", instruction, 32'h0);
        check("reset_pc4", pc_plus_4, 32'h0);
        check("reset_ferr", {31'h0, fetch_error}, 32'h0);
        check("reset_state", {30'h0, fetch_state}, {30'h0, FETCH_BOOT});
        reset = 1'b1;

        for (int n = 0; n < 21; n++) begin
            drive(vecs[n].stall, vecs[n].jump, vecs[n].jt, vecs[n].bt, vecs[n].btgt, vecs[n].rdy);
            #1;
            check($sformatf("v%0d_req", n), {31'h0, imem_req}, {31'h0, vecs[n].req});
            check($sformatf("v%0d_addr", n), imem_addr, vecs[n].addr);
            if (vecs[n].vld && vecs[n].req)
                exp_q.push_back({vecs[n].ins, vecs[n].p4});
            edge_step();
            check($sformatf("v%0d_valid", n), {31'h0, valid}, {31'h0, vecs[n].vld});
            check($sformatf("v%0d_instr", n), instruction, vecs[n].ins);
            check($sformatf("v%0d_pc4", n), pc_plus_4, vecs[n].p4);
            check($sformatf("v%0d_ferr", n), {31'h0, fetch_error}, {31'h0, vecs[n].ferr});
            check($sformatf("v%0d_state", n), {30'h0, fetch_state}, {30'h0, vecs[n].st});
            if (vecs[n].req && valid)
                pop_compare($sformatf("v%0d_sb", n));
        end
        check("table_queue_empty", exp_q.size(), 32'h0);

        // Reset out of HALT clears the sticky error.
        reset = 1'b0;
        drive(1'b0, 1'b1, 26'h5, 1'b1, 32'h202, 1'b1);
        edge_step();
        check("halt_rst_ferr", {31'h0, fetch_error}, 32'h0);
        check("halt_rst_valid", {31'h0, valid}, 32'h0);
        check("halt_rst_state", {30'h0, fetch_state}, {30'h0, FETCH_BOOT});
        check("halt_rst_req", {31'h0, imem_req}, 32'h0);
        check("halt_rst_addr", imem_addr, 32'h100);

        // Random memory wait states with a non-trivial memory image.
        mem_key = 32'h5A5A_0000;
        reset = 1'b1;
        drive(1'b0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b1);
        #1;
        check("boot_req", {31'h0, imem_req}, 32'h0);
        edge_step();
        mpc = 32'h100;
        for (int n = 0; n < 40; n++) begin
            rdy = 1'($urandom_range(0, 1));
            imem_ready = rdy;
            #1;
            check($sformatf("r%0d_addr", n), imem_addr, mpc);
            if (rdy) exp_q.push_back({mpc ^ mem_key, mpc + 32'd4});
            edge_step();
            check($sformatf("r%0d_valid", n), {31'h0, valid}, {31'h0, rdy});
            if (valid) pop_compare($sformatf("r%0d_sb", n));
            if (rdy) mpc = mpc + 32'd4;
        end
        check("rand_queue_empty", exp_q.size(), 32'h0);

        // Reset asserted while stalled with a redirect pending.
        reset = 1'b0;
        drive(1'b1, 1'b1, 26'h7, 1'b1, 32'h400, 1'b1);
        edge_step();
        check("stall_rst_state", {30'h0, fetch_state}, {30'h0, FETCH_BOOT});
        check("stall_rst_valid", {31'h0, valid}, 32'h0);
        check("stall_rst_pc4", pc_plus_4, 32'h0);
        check("stall_rst_addr", imem_addr, 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
